// File: rtl/spi_pkg.sv
// SPI peripheral shared definitions: controller states, default geometry and
// control-register field offsets.
// Pure declarations; no logic, no latency, no flow control.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_LOAD      = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_BYTE_DONE = 3'd4,
        ST_CHECK     = 3'd5,
        ST_DONE      = 3'd6
    } spi_state_t;

    // Default geometry: 10 MHz system clock / (2*5) = 1 MHz SCLK.
    localparam int CLK_DIV_DEF = 5;
    localparam int DATA_W_DEF  = 8;
    localparam int ADDR_W_DEF  = 9;

    // Control register layout.
    localparam int CTRL_SEND_BIT = 0;
    localparam int CTRL_ALL1_BIT = 1;
    localparam int CTRL_ALL0_BIT = 2;
    localparam int CTRL_NEND_LSB = 3;
    localparam int CTRL_NEND_W   = 9;

    function automatic logic is_busy(input spi_state_t s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: half-period divider producing a mode-0 SCLK and edge strobes.
// Latency: strobes are combinational and coincide with the clk_i edge that flips sclk.
// Backpressure: none; runs only while en=1, returns to sclk=0 / zero counts on clr.
//
// Ports:
//   clk_i, rst       system clock, synchronous active-low reset
//   clr              restart: sclk low, divider and bit count zeroed
//   en               advance the divider this cycle
//   sclk             registered SPI clock, idles low
//   rise_stb         this cycle's clk_i edge takes sclk 0->1
//   fall_stb         this cycle's clk_i edge takes sclk 1->0
//   bit_cnt          number of falling edges completed since clr
module spi_sclk_gen #(
    parameter int CLK_DIV = 5,
    parameter int BITS    = 8
) (
    input  logic                      clk_i,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      en,
    output logic                      sclk,
    output logic                      rise_stb,
    output logic                      fall_stb,
    output logic [$clog2(BITS)-1:0]   bit_cnt
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int BCNT_W = $clog2(BITS);

    logic [DIV_W-1:0] div_cnt;
    logic             half_end;

    assign half_end = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign rise_stb = en && half_end && !sclk;
    assign fall_stb = en && half_end && sclk;

    always_ff @(posedge clk_i) begin
        if (!rst || clr) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
            bit_cnt <= '0;
        end else if (en) begin
            if (half_end) begin
                div_cnt <= '0;
                sclk    <= !sclk;
                if (sclk) begin
                    bit_cnt <= bit_cnt + BCNT_W'(1);
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_transaction_ctrl.sv
// SPI mode-0 transaction controller: sequences CS, byte loads from TX RAM, MSB-first shifting, RX RAM writes.
// Latency: START at the edge after send_i seen in IDLE; each byte takes 16*CLK_DIV+3 cycles.
// Backpressure: none; control fields are captured on start and later changes are ignored until IDLE.
//
// Ports:
//   clk_i, rst                       system clock, synchronous active-low reset
//   send_i, n_tx_end_i,
//   all_1s_i, all_0s_i               control register fields (length = n_tx_end_i+1 bytes)
//   byte_cnt_i, fin_trans_i          external byte counter value and terminal flag
//   cnt_en_o, cnt_rst_o              byte counter increment / clear pulses
//   tx_addr_o, tx_data_i             TX RAM read port (combinational data)
//   rx_we_o, rx_addr_o, rx_data_o    RX RAM write port
//   send_clr_o                       clears the send bit at the end of a transaction
//   busy_o                           high outside IDLE
//   sclk_o, mosi_o, miso_i, cs_o     SPI pins (cs_o active-low)
module spi_transaction_ctrl
    import spi_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst,
    input  logic              send_i,
    input  logic [ADDR_W-1:0] n_tx_end_i,
    input  logic              all_1s_i,
    input  logic              all_0s_i,
    input  logic [ADDR_W:0]   byte_cnt_i,
    input  logic              fin_trans_i,
    output logic              cnt_en_o,
    output logic              cnt_rst_o,
    output logic [ADDR_W-1:0] tx_addr_o,
    input  logic [DATA_W-1:0] tx_data_i,
    output logic              rx_we_o,
    output logic [ADDR_W-1:0] rx_addr_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              send_clr_o,
    output logic              busy_o,
    output logic              sclk_o,
    output logic              mosi_o,
    input  logic              miso_i,
    output logic              cs_o
);

    localparam int BCNT_W = $clog2(DATA_W);

    spi_state_t          state;
    spi_state_t          state_nxt;

    logic [DATA_W-1:0]   shift_reg;
    logic                miso_bit;
    logic [ADDR_W-1:0]   n_end_q;
    logic                all1_q;
    logic                all0_q;

    logic                sclk;
    logic                rise_stb;
    logic                fall_stb;
    logic [BCNT_W-1:0]   bit_cnt;
    logic                last_fall;

    logic [ADDR_W:0]     end_cnt;
    logic                own_fin;
    logic                fin;
    logic [DATA_W-1:0]   load_val;

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV),
        .BITS    (DATA_W)
    ) u_sclk_gen (
        .clk_i    (clk_i),
        .rst      (rst),
        .clr      (state == ST_LOAD),
        .en       (state == ST_SHIFT),
        .sclk     (sclk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
        .bit_cnt  (bit_cnt)
    );

    assign last_fall = fall_stb && (bit_cnt == BCNT_W'(DATA_W - 1));

    // The external counter compares against the live control field. While that
    // field still matches the value captured at start its flag is trusted;
    // once software has rewritten it mid-transfer, the captured length decides.
    assign end_cnt = {1'b0, n_end_q} + {{ADDR_W{1'b0}}, 1'b1};
    assign own_fin = (byte_cnt_i == end_cnt);
    assign fin     = (n_tx_end_i == n_end_q) ? fin_trans_i : own_fin;

    // all_1s has priority over all_0s.
    assign load_val = all1_q ? {DATA_W{1'b1}} :
                      all0_q ? {DATA_W{1'b0}} : tx_data_i;

    always_ff @(posedge clk_i) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cs_o       = 1'b0;
        cnt_rst_o  = 1'b0;
        cnt_en_o   = 1'b0;
        rx_we_o    = 1'b0;
        send_clr_o = 1'b0;
        busy_o     = is_busy(state);
        case (state)
            ST_IDLE: begin
                cs_o = 1'b1;
                if (send_i) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                cnt_rst_o = 1'b1;
                state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (last_fall) begin
                    state_nxt = ST_BYTE_DONE;
                end
            end
            ST_BYTE_DONE: begin
                rx_we_o   = 1'b1;
                cnt_en_o  = 1'b1;
                state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                // Counter has already absorbed this byte's increment here.
                state_nxt = fin ? ST_DONE : ST_LOAD;
            end
            ST_DONE: begin
                cs_o       = 1'b1;
                send_clr_o = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: begin
                cs_o      = 1'b1;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst) begin
            shift_reg <= '0;
            miso_bit  <= 1'b0;
            n_end_q   <= '0;
            all1_q    <= 1'b0;
            all0_q    <= 1'b0;
        end else begin
            if (state == ST_IDLE && send_i) begin
                n_end_q <= n_tx_end_i;
                all1_q  <= all_1s_i;
                all0_q  <= all_0s_i;
            end
            if (state == ST_LOAD) begin
                shift_reg <= load_val;
            end else if (fall_stb) begin
                shift_reg <= {shift_reg[DATA_W-2:0], miso_bit};
            end
            // Sampled on the rising SCLK edge, shifted in on the following falling edge.
            if (rise_stb) begin
                miso_bit <= miso_i;
            end
        end
    end

    assign sclk_o    = sclk;
    assign mosi_o    = shift_reg[DATA_W-1];
    assign rx_data_o = shift_reg;
    assign tx_addr_o = byte_cnt_i[ADDR_W-1:0];
    assign rx_addr_o = byte_cnt_i[ADDR_W-1:0];

endmodule

// File: tb/tb_spi_transaction_ctrl.sv
module tb_spi_transaction_ctrl;
    import spi_pkg::*;

    localparam int C         = 5;
    localparam int SHIFT_CYC = 16 * C;

    logic        clk = 1'b0;
    always #5 clk = !clk;

    logic        rst;
    logic [11:0] ctrl;
    logic        loop;

    logic        send, all1, all0;
    logic [8:0]  n_end;
    assign send  = ctrl[CTRL_SEND_BIT];
    assign all1  = ctrl[CTRL_ALL1_BIT];
    assign all0  = ctrl[CTRL_ALL0_BIT];
    assign n_end = ctrl[CTRL_NEND_LSB +: CTRL_NEND_W];

    logic [9:0]  byte_cnt;
    logic        fin_trans;
    logic        cnt_en, cnt_rst, rx_we, send_clr, busy, sclk, mosi, miso, cs;
    logic [8:0]  tx_addr, rx_addr;
    logic [7:0]  tx_data, rx_data;

    logic [7:0]  tx_ram [0:511];
    logic [7:0]  rx_ram [0:511];

    spi_transaction_ctrl #(.CLK_DIV(C), .DATA_W(8), .ADDR_W(9)) dut (
        .clk_i       (clk),
        .rst         (rst),
        .send_i      (send),
        .n_tx_end_i  (n_end),
        .all_1s_i    (all1),
        .all_0s_i    (all0),
        .byte_cnt_i  (byte_cnt),
        .fin_trans_i (fin_trans),
        .cnt_en_o    (cnt_en),
        .cnt_rst_o   (cnt_rst),
        .tx_addr_o   (tx_addr),
        .tx_data_i   (tx_data),
        .rx_we_o     (rx_we),
        .rx_addr_o   (rx_addr),
        .rx_data_o   (rx_data),
        .send_clr_o  (send_clr),
        .busy_o      (busy),
        .sclk_o      (sclk),
        .mosi_o      (mosi),
        .miso_i      (miso),
        .cs_o        (cs)
    );

    // Byte counter and RAMs around the controller.
    always @(posedge clk) begin
        if (!rst || cnt_rst) byte_cnt <= 10'd0;
        else if (cnt_en)     byte_cnt <= byte_cnt + 10'd1;
    end
    assign fin_trans = (byte_cnt == ({1'b0, n_end} + 10'd1));
    assign tx_data   = tx_ram[tx_addr];
    assign miso      = loop ? mosi : 1'b0;

    always @(posedge clk) begin
        if (rx_we === 1'b1) rx_ram[rx_addr] <= rx_data;
    end

    // Event counters sampled mid-cycle.
    int   n_we = 0, n_en = 0, n_rst = 0, n_clr = 0, n_busy = 0, n_mhi = 0;
    logic [7:0] mosi_cap = 8'h00;
    logic       prev_sclk = 1'b0;
    always @(negedge clk) begin
        if (rx_we === 1'b1)    n_we   <= n_we + 1;
        if (cnt_en === 1'b1)   n_en   <= n_en + 1;
        if (cnt_rst === 1'b1)  n_rst  <= n_rst + 1;
        if (send_clr === 1'b1) n_clr  <= n_clr + 1;
        if (busy === 1'b1)     n_busy <= n_busy + 1;
        if (sclk === 1'b1 && mosi === 1'b1) n_mhi <= n_mhi + 1;
        if (sclk === 1'b1 && prev_sclk === 1'b0) mosi_cap <= {mosi_cap[6:0], mosi};
        prev_sclk <= sclk;
    end

    // Expected per-cycle outputs: {busy,cs,sclk,mosi,cnt_rst,cnt_en,rx_we,send_clr,tx_addr,rx_addr,rx_data}
    typedef struct packed {
        logic [33:0] val;
        logic [33:0] mask;
    } exp_t;

    localparam logic [33:0] M_BASE  = {8'hEF, 26'h0};
    localparam logic [33:0] M_FLAGS = {8'hFF, 26'h0};
    localparam logic [33:0] M_TXA   = {8'h00, 9'h1FF, 17'h0};
    localparam logic [33:0] M_RX    = {17'h0, 9'h1FF, 8'hFF};
    localparam logic [33:0] M_ALL   = {34{1'b1}};

    exp_t       q[$];
    logic [7:0] txb [0:7];
    int         total = 0, bad = 0;

    function automatic exp_t rec(input logic b, input logic c, input logic s, input logic m,
                                 input logic cr, input logic ce, input logic we, input logic cl,
                                 input logic [8:0] ta, input logic [8:0] ra, input logic [7:0] rd,
                                 input logic [33:0] mask);
        exp_t e;
        e.val  = {b, c, s, m, cr, ce, we, cl, ta, ra, rd};
        e.mask = mask;
        return e;
    endfunction

    task automatic push_idle();
        q.push_back(rec(0, 1, 0, 0, 0, 0, 0, 0, 9'd0, 9'd0, 8'd0, M_BASE));
    endtask

    task automatic push_reset();
        q.push_back(rec(0, 1, 0, 0, 0, 0, 0, 0, 9'd0, 9'd0, 8'd0, M_ALL));
    endtask

    // One whole transaction from START to DONE, built from the protocol rules.
    task automatic push_txn(input int nb, input bit lp);
        logic [7:0] rxb;
        int half, bi;
        q.push_back(rec(1, 0, 0, 0, 1, 0, 0, 0, 9'd0, 9'd0, 8'd0, M_BASE));
        for (int k = 0; k < nb; k++) begin
            q.push_back(rec(1, 0, 0, 0, 0, 0, 0, 0, 9'(k), 9'd0, 8'd0, M_BASE | M_TXA));
            for (int j = 0; j < SHIFT_CYC; j++) begin
                half = j / C;
                bi   = half / 2;
                q.push_back(rec(1, 0, half[0], txb[k][7 - bi], 0, 0, 0, 0,
                                9'd0, 9'd0, 8'd0, M_FLAGS));
            end
            rxb = lp ? txb[k] : 8'h00;
            q.push_back(rec(1, 0, 0, 0, 0, 1, 1, 0, 9'd0, 9'(k), rxb, M_BASE | M_RX));
            q.push_back(rec(1, 0, 0, 0, 0, 0, 0, 0, 9'd0, 9'd0, 8'd0, M_BASE));
        end
        q.push_back(rec(1, 1, 0, 0, 0, 0, 0, 1, 9'd0, 9'd0, 8'd0, M_BASE));
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_clr(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (send_clr === 1'b1) ok = 1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_send_clr got=timeout want=pulse within %0d cycles", budget);
        end
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (q.size() > 0 && i < 3000) begin
            step();
            i++;
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain got=%0d pending want=0", q.size());
            q.delete();
        end
    endtask

    task automatic set_ctrl(input bit s, input bit a1, input bit a0, input int ne);
        ctrl = 12'd0;
        ctrl[CTRL_SEND_BIT] = s;
        ctrl[CTRL_ALL1_BIT] = a1;
        ctrl[CTRL_ALL0_BIT] = a0;
        ctrl[CTRL_NEND_LSB +: CTRL_NEND_W] = 9'(ne);
    endtask

    int   b_we, b_en, b_rst, b_clr, b_busy, b_mhi;
    exp_t keep;
    exp_t ce;
    logic [33:0] got;

    task automatic snap();
        b_we = n_we; b_en = n_en; b_rst = n_rst; b_clr = n_clr; b_busy = n_busy; b_mhi = n_mhi;
    endtask

    initial begin
        rst  = 1'b0;
        loop = 1'b0;
        set_ctrl(0, 0, 0, 0);
        for (int i = 0; i < 512; i++) tx_ram[i] = 8'(i * 7 + 3);

        fork
            forever begin
                @(negedge clk);
                if (q.size() > 0) begin
                    ce  = q.pop_front();
                    got = {busy, cs, sclk, mosi, cnt_rst, cnt_en, rx_we, send_clr,
                           tx_addr, rx_addr, rx_data};
                    total++;
                    if (((got ^ ce.val) & ce.mask) !== 34'h0) begin
                        bad++;
                        $display("FAIL cycle t=%0t got=%h want=%h mask=%h", $time, got, ce.val, ce.mask);
                    end
                end
            end
        join_none

        // Reset state
        step();
        push_reset();
        push_reset();
        step();
        step();
        rst = 1'b1;
        drain();

        // 1: single byte 0xA5, loopback
        tx_ram[0] = 8'hA5;
        txb[0] = 8'hA5;
        loop = 1'b1;
        snap();
        push_idle();
        push_txn(1, 1);
        set_ctrl(1, 0, 0, 0);
        wait_clr(500);
        set_ctrl(0, 0, 0, 0);
        push_idle();
        drain();
        chk("t1_rx0", rx_ram[0], 8'hA5);
        chk("t1_we", n_we - b_we, 1);
        chk("t1_busy", n_busy - b_busy, 85);
        chk("t1_mosi", mosi_cap, 8'hA5);

        // 2: three bytes, MISO tied low
        tx_ram[0] = 8'h12; tx_ram[1] = 8'h34; tx_ram[2] = 8'h56;
        txb[0] = 8'h12; txb[1] = 8'h34; txb[2] = 8'h56;
        loop = 1'b0;
        snap();
        push_idle();
        push_txn(3, 0);
        set_ctrl(1, 0, 0, 2);
        wait_clr(1000);
        set_ctrl(0, 0, 0, 2);
        push_idle();
        drain();
        chk("t2_en", n_en - b_en, 3);
        chk("t2_clr", n_clr - b_clr, 1);
        chk("t2_rx0", rx_ram[0], 8'h00);
        chk("t2_rx2", rx_ram[2], 8'h00);

        // 3: all_1s and all_0s together, RAM content ignored
        tx_ram[0] = 8'h3C; tx_ram[1] = 8'hC3;
        txb[0] = 8'hFF; txb[1] = 8'hFF;
        loop = 1'b1;
        snap();
        push_idle();
        push_txn(2, 1);
        set_ctrl(1, 1, 1, 1);
        wait_clr(1000);
        set_ctrl(0, 1, 1, 1);
        push_idle();
        drain();
        chk("t3_mosi_hi", n_mhi - b_mhi, 80);
        chk("t3_rx1", rx_ram[1], 8'hFF);

        // 4: reset during SHIFT of byte 1
        tx_ram[0] = 8'h81; tx_ram[1] = 8'h7E; tx_ram[2] = 8'h99;
        txb[0] = 8'h81; txb[1] = 8'h7E; txb[2] = 8'h99;
        snap();
        push_idle();
        push_txn(3, 1);
        set_ctrl(1, 0, 0, 2);
        repeat (100) step();
        keep = q[0];
        q.delete();
        q.push_back(keep);
        push_reset();
        push_reset();
        push_reset();
        rst = 1'b0;
        set_ctrl(0, 0, 0, 2);
        step();
        rst = 1'b1;
        drain();
        chk("t4_clr", n_clr - b_clr, 0);
        chk("t4_we", n_we - b_we, 1);

        // 5: send held high, back-to-back transactions
        tx_ram[0] = 8'h6D;
        txb[0] = 8'h6D;
        snap();
        push_idle();
        push_txn(1, 1);
        push_idle();
        push_txn(1, 1);
        set_ctrl(1, 0, 0, 0);
        wait_clr(500);
        wait_clr(500);
        set_ctrl(0, 0, 0, 0);
        push_idle();
        drain();
        chk("t5_rst", n_rst - b_rst, 2);
        chk("t5_clr", n_clr - b_clr, 2);

        // 6: control changes mid-transfer are ignored
        tx_ram[0] = 8'hC3; tx_ram[1] = 8'h5A; tx_ram[2] = 8'h0F; tx_ram[3] = 8'hE1;
        txb[0] = 8'hC3; txb[1] = 8'h5A; txb[2] = 8'h0F; txb[3] = 8'hE1;
        snap();
        push_idle();
        push_txn(4, 1);
        set_ctrl(1, 0, 0, 3);
        repeat (50) step();
        set_ctrl(0, 1, 0, 0);
        repeat (100) step();
        set_ctrl(1, 0, 1, 2);
        wait_clr(2000);
        set_ctrl(0, 0, 0, 0);
        push_idle();
        drain();
        chk("t6_en", n_en - b_en, 4);
        chk("t6_we", n_we - b_we, 4);
        chk("t6_rx3", rx_ram[3], 8'hE1);

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
